// File: rtl/ucsbece154b_mem_arbiter.sv
// Fetch/data arbiter sharing one single-ported memory over a req/ack handshake.
// Data wins ties, except that a bounded streak of data wins forces a fetch grant.
module ucsbece154b_mem_arbiter #(
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          f_req_i,
  input  logic [DW-1:0] f_addr_i,
  output logic [DW-1:0] f_rdata_o,
  output logic          f_ready_o,
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [DW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  output logic [DW-1:0] d_rdata_o,
  output logic          d_ready_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [DW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_ack_i,
  output logic          grant_d_o
);

  localparam int unsigned SW = 4;
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIM);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state;
  logic [SW-1:0] streak;
  logic          pick_d_c;

  // Data wins unless a fetch is pending and has already lost LIM times in a row.
  assign pick_d_c = d_req_i && (!f_req_i || (streak < LIM));

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      streak      <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      f_rdata_o   <= '0;
      d_rdata_o   <= '0;
      f_ready_o   <= 1'b0;
      d_ready_o   <= 1'b0;
      grant_d_o   <= 1'b0;
    end else begin
      f_ready_o <= 1'b0;
      d_ready_o <= 1'b0;
      case (state)
        IDLE: begin
          if (f_req_i || d_req_i) begin
            state     <= BUSY;
            mem_req_o <= 1'b1;
            grant_d_o <= pick_d_c;
            if (pick_d_c) begin
              mem_we_o    <= d_we_i;
              mem_addr_o  <= d_addr_i;
              mem_wdata_o <= d_wdata_i;
              if (f_req_i && (streak < LIM)) streak <= streak + SW'(1);
            end else begin
              mem_we_o    <= 1'b0;
              mem_addr_o  <= f_addr_i;
              mem_wdata_o <= '0;
              streak      <= '0;
            end
          end
        end
        BUSY: begin
          if (mem_ack_i) begin
            state     <= RESP;
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
            if (grant_d_o) begin
              d_ready_o <= 1'b1;
              if (!mem_we_o) d_rdata_o <= mem_rdata_i;
            end else begin
              f_ready_o <= 1'b1;
              f_rdata_o <= mem_rdata_i;
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ucsbece154b_mem_arbiter.md
Name: ucsbece154b_mem_arbiter

Overview:
Two-requester arbiter that shares one single-ported unified memory between the pipeline's instruction-fetch port (PCF/InstrF) and its data port (ALUResultM/WriteDataM/MemWriteM/ReadDataM).
It serialises accesses through a 3-state FSM over a req/ack memory handshake. Data accesses have priority, and a starvation counter guarantees fetch progress.
The hazard logic converts the not-ready condition of each port into StallF/StallD.

Parameters:
DW, 32, data/address width in bits
STARVE_LIM, 4, consecutive data grants won against a pending fetch before fetch is forced to win (1..15)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
f_req_i  input  1  fetch request; held high until f_ready_o
f_addr_i  input  DW  fetch address (PCF)
f_rdata_o  output  DW  fetched instruction; registered, held until next fetch completion
f_ready_o  output  1  one-cycle pulse: fetch complete
d_req_i  input  1  data request; held high until d_ready_o
d_we_i  input  1  1 = store, 0 = load
d_addr_i  input  DW  data address (ALUResultM)
d_wdata_i  input  DW  store data (WriteDataM)
d_rdata_o  output  DW  load data; registered, held until next load completion
d_ready_o  output  1  one-cycle pulse: data access complete
mem_req_o  output  1  memory request, high for the whole BUSY state
mem_we_o  output  1  memory write enable, valid while mem_req_o
mem_addr_o  output  DW  memory address, stable while mem_req_o
mem_wdata_o  output  DW  memory write data, stable while mem_req_o
mem_rdata_i  input  DW  memory read data, valid in the mem_ack_i cycle
mem_ack_i  input  1  memory completion, sampled only in BUSY
grant_d_o  output  1  owner of current/last transaction: 1 = data, 0 = fetch

Behaviour:
- Reset (synchronous): state=IDLE; mem_req_o=0, mem_we_o=0; mem_addr_o, mem_wdata_o, f_rdata_o, d_rdata_o = 0; f_ready_o=d_ready_o=0; grant_d_o=0; streak counter=0.
- Reset applied in BUSY or RESP aborts the access. No ready pulse is issued. A late mem_ack_i arriving after reset is ignored.
- IDLE: with no request, stay in IDLE with all outputs inactive. If any request is high:
  - choose the owner;
  - latch addr, we (0 for fetch), and wdata (d_wdata_i for data, 0 for fetch) into the mem_* output registers;
  - set grant_d_o;
  - go to BUSY.
- Arbitration:
  - Only d_req_i high: data wins.
  - Only f_req_i high: fetch wins.
  - Both high: data wins if streak < STARVE_LIM, otherwise fetch wins.
- Streak counter:
  - Increments (saturating at STARVE_LIM) on a data grant made while f_req_i=1.
  - Clears on any fetch grant.
  - Unchanged on a data grant made while f_req_i=0.
- BUSY: mem_req_o=1 and mem_* outputs are stable. Wait indefinitely for mem_ack_i. On mem_ack_i=1, go to RESP and:
  - fetch owner: f_rdata_o <= mem_rdata_i;
  - data load: d_rdata_o <= mem_rdata_i;
  - data store: d_rdata_o unchanged.
- RESP: mem_req_o=0, mem_we_o=0. The owner's ready_o=1 for exactly this cycle. Unconditionally return to IDLE. No grant is made in RESP.
- Timing: a request sampled at edge k gives BUSY in cycle k+1. With ack in that same cycle, RESP (ready high) is cycle k+2. Minimum 3 cycles per access. Back-to-back accesses from the same port are at least 3 cycles apart.
- Requester contract:
  - Hold req and operands stable until the ready cycle, and drop req on the edge ending the ready cycle unless a new access is wanted.
  - Changes to req or operands after a grant are ignored; the latched transaction always completes.
- mem_ack_i in IDLE or RESP is ignored. Only one transaction is ever outstanding.
- f_ready_o and d_ready_o are never high in the same cycle.

Test Plan:
- Lone fetch: f_req_i=1, f_addr_i=0x00000010, memory acks in the first BUSY cycle with 0x00500093 -> mem_req_o high 1 cycle with mem_addr_o=0x10, mem_we_o=0; f_ready_o pulses 2 cycles after the req is sampled; f_rdata_o=0x00500093 and held thereafter.
- Simultaneous requests: f_req_i=d_req_i=1, d_we_i=1, d_addr_i=0x2000, d_wdata_i=0xDEADBEEF -> data granted first (mem_we_o=1, mem_wdata_o=0xDEADBEEF), d_ready_o pulses, d_rdata_o unchanged; the fetch is then granted on the next IDLE and completes.
- Starvation, STARVE_LIM=4: f_req_i held high, d_req_i re-asserted every opportunity -> grant sequence D,D,D,D,F,D,D,D,D,F; exactly 4 data grants between fetch grants.
- Delayed ack: data load to 0x40, mem_ack_i withheld 5 cycles then asserted with 0x12345678 -> mem_req_o and mem_addr_o=0x40 stable for all 6 BUSY cycles; d_ready_o pulses once; d_rdata_o=0x12345678.
- Reset mid-access: reset asserted in the 2nd BUSY cycle of a fetch, then mem_ack_i=1 the next cycle -> mem_req_o=0 after the reset edge, no f_ready_o pulse, f_rdata_o=0, FSM in IDLE, streak=0.
- Req drop after grant: d_req_i deasserted the cycle after the grant -> transaction still completes and d_ready_o still pulses once.
